// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants and state encoding for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    localparam int DMEM_WORD_LEN    = 32;
    localparam int DMEM_BURST_W     = 4;
    localparam int DMEM_STARVE_MAX  = 3;
    localparam int DMEM_WORD_STRIDE = 2;

    typedef enum logic [1:0] {
        DMEM_ARB_IDLE  = 2'd0,
        DMEM_ARB_BURST = 2'd1,
        DMEM_ARB_DONE  = 2'd2
    } dmem_arb_state_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts consecutive CPU grants while a DMA beat waits; saturates at STARVE_MAX.
module dmem_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic starve_hit
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt;

    assign starve_hit = (cnt >= CNT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !starve_hit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM-stage CPU port and a burst DMA port.
// state | meaning
// IDLE  | no burst; CPU owns the memory, dma_start sampled
// BURST | DMA beats pending; CPU has priority up to STARVE_MAX grants in a row
// DONE  | one-cycle dma_done pulse; CPU still served
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int WORD_LEN   = DMEM_WORD_LEN,
    parameter int BURST_W    = DMEM_BURST_W,
    parameter int STARVE_MAX = DMEM_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [WORD_LEN-1:0] cpu_addr,
    input  logic [WORD_LEN-1:0] cpu_wdata,
    output logic [WORD_LEN-1:0] cpu_rdata,
    output logic                cpu_stall,
    input  logic                dma_start,
    input  logic                dma_we,
    input  logic [WORD_LEN-1:0] dma_base,
    input  logic [BURST_W-1:0]  dma_len,
    input  logic [WORD_LEN-1:0] dma_wdata,
    output logic                dma_wready,
    output logic [WORD_LEN-1:0] dma_rdata,
    output logic                dma_rvalid,
    output logic                dma_busy,
    output logic                dma_done,
    output logic                mem_we,
    output logic                mem_re,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);
    dmem_arb_state_e     state;
    logic [WORD_LEN-1:0] cur_addr;
    logic [BURST_W-1:0]  remaining;
    logic                dir_we;
    logic                in_burst;
    logic                starve_hit;
    logic                cpu_grant;
    logic                dma_beat;

    assign in_burst  = (state == DMEM_ARB_BURST);
    assign cpu_grant = cpu_req & ~(in_burst & starve_hit);
    assign dma_beat  = in_burst & ~cpu_grant;

    assign cpu_stall = cpu_req & dma_beat;
    assign dma_busy  = in_burst;
    assign dma_done  = (state == DMEM_ARB_DONE);

    dmem_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .clr        (~in_burst | dma_beat),
        .inc        (in_burst & cpu_grant),
        .starve_hit (starve_hit)
    );

    always_comb begin
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_rdata  = '0;
        dma_wready = 1'b0;
        if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_re    = ~cpu_we;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
        end else if (dma_beat) begin
            mem_addr = cur_addr;
            if (dir_we) begin
                mem_we     = 1'b1;
                mem_wdata  = dma_wdata;
                dma_wready = 1'b1;
            end else begin
                mem_re = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DMEM_ARB_IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            dir_we     <= 1'b0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= dma_beat & ~dir_we;
            if (dma_beat && !dir_we) begin
                dma_rdata <= mem_rdata;
            end
            case (state)
                DMEM_ARB_IDLE: begin
                    if (dma_start) begin
                        if (dma_len != '0) begin
                            // Bursts are word aligned; the byte-pair LSB is dropped.
                            cur_addr  <= dma_base & ~WORD_LEN'(1);
                            remaining <= dma_len;
                            dir_we    <= dma_we;
                            state     <= DMEM_ARB_BURST;
                        end else begin
                            state <= DMEM_ARB_DONE;
                        end
                    end
                end
                DMEM_ARB_BURST: begin
                    if (dma_beat) begin
                        cur_addr  <= cur_addr + WORD_LEN'(DMEM_WORD_STRIDE);
                        remaining <= remaining - BURST_W'(1);
                        if (remaining == BURST_W'(1)) begin
                            state <= DMEM_ARB_DONE;
                        end
                    end
                end
                DMEM_ARB_DONE: state <= DMEM_ARB_IDLE;
                default:       state <= DMEM_ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: DMA beats are scored against queued expectations.
module tb_dmem_port_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_start, dma_we;
    logic [31:0] dma_base;
    logic [3:0]  dma_len;
    logic [31:0] dma_wdata, dma_rdata;
    logic        dma_wready, dma_rvalid, dma_busy, dma_done;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    wexp_t       wq[$];
    logic [31:0] rq[$];
    logic [31:0] wr_data [0:15];
    int          wr_idx;
    int          tests = 0;
    int          failed = 0;
    int          done_cnt = 0;
    logic [63:0] grant_log, stall_log, rv_log;
    int          done_at;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:1]];
    always @(posedge clk) if (mem_we) mem[mem_addr[8:1]] <= mem_wdata;

    dmem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_start  (dma_start),
        .dma_we     (dma_we),
        .dma_base   (dma_base),
        .dma_len    (dma_len),
        .dma_wdata  (dma_wdata),
        .dma_wready (dma_wready),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .dma_busy   (dma_busy),
        .dma_done   (dma_done),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop one expectation per DMA write beat / read return.
    always @(negedge clk) begin
        if (!rst) begin
            if (dma_wready) begin
                if (wq.size() == 0) begin
                    chk("wq_underflow", 32'(wq.size()), 32'd1);
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("dma_waddr", mem_addr, e.addr);
                    chk("dma_wdata", mem_wdata, e.data);
                    chk("dma_mem_we", 32'(mem_we), 32'd1);
                end
            end
            if (dma_rvalid) begin
                if (rq.size() == 0) chk("rq_underflow", 32'(rq.size()), 32'd1);
                else chk("dma_rdata", dma_rdata, rq.pop_front());
            end
            if (dma_done) done_cnt++;
        end
    end

    task automatic burst_run(input int budget, input int restart_at);
        int  cyc;
        logic seen;
        cyc = 0;
        done_at = -1;
        grant_log = '0;
        stall_log = '0;
        rv_log = '0;
        while (done_at < 0 && cyc < budget) begin
            if (cyc == restart_at) begin
                dma_start = 1'b1;
                dma_len   = 4'd15;
                dma_base  = 32'h100;
            end
            @(negedge clk);
            grant_log[cyc] = dma_wready | (dma_busy & mem_re & ~cpu_req);
            stall_log[cyc] = cpu_stall;
            rv_log[cyc]    = dma_rvalid;
            seen = dma_wready;
            if (dma_done) done_at = cyc;
            step();
            dma_start = 1'b0;
            if (seen && wr_idx < 15) begin
                wr_idx++;
                dma_wdata = wr_data[wr_idx];
            end
            cyc++;
        end
        if (done_at < 0) chk("burst_timeout", 32'(cyc), 32'(budget + 1));
    endtask

    task automatic start_write(input logic [31:0] base, input logic [3:0] len, input logic [31:0] d0);
        for (int i = 0; i < 16; i++) wr_data[i] = d0 + 32'(i);
        for (int i = 0; i < int'(len); i++) wq.push_back('{addr: (base & ~32'd1) + 32'(2 * i), data: d0 + 32'(i)});
        wr_idx    = 0;
        dma_wdata = wr_data[0];
        dma_we    = 1'b1;
        dma_base  = base;
        dma_len   = len;
        dma_start = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_start = 0; dma_we = 0; dma_base = 0; dma_len = 0; dma_wdata = 0;
        wr_idx = 0;
        step();
        step();
        chk("rst_cpu_stall", 32'(cpu_stall), 0);
        chk("rst_dma_busy", 32'(dma_busy), 0);
        chk("rst_dma_done", 32'(dma_done), 0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
        chk("rst_dma_wready", 32'(dma_wready), 0);
        chk("rst_mem_we_re", {30'd0, mem_we, mem_re}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        rst = 1'b0;

        // CPU store then load
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1;
        chk("st_stall", 32'(cpu_stall), 0);
        chk("st_mem_we", 32'(mem_we), 1);
        chk("st_mem_addr", mem_addr, 32'h10);
        step();
        cpu_we = 0;
        #1;
        chk("ld_stall", 32'(cpu_stall), 0);
        chk("ld_mem_re", 32'(mem_re), 1);
        chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
        step();
        cpu_req = 0;

        // DMA write burst, base 0x21 len 3
        start_write(32'h21, 4'd3, 32'd1);
        #1;
        chk("w_idle_busy", 32'(dma_busy), 0);
        step();
        dma_start = 0;
        burst_run(20, -1);
        chk("w_grants", grant_log[31:0], 32'h7);
        chk("w_done_at", 32'(done_at), 3);
        chk("w_wq_left", 32'(wq.size()), 0);
        cpu_req = 1; cpu_we = 0;
        for (int i = 0; i < 3; i++) begin
            cpu_addr = 32'h20 + 32'(2 * i);
            #1;
            chk("w_readback", cpu_rdata, 32'(i + 1));
            step();
        end
        cpu_req = 0;

        // DMA read burst, base 0x20 len 2
        rq.push_back(32'd1);
        rq.push_back(32'd2);
        dma_we = 0; dma_base = 32'h20; dma_len = 4'd2; dma_start = 1;
        step();
        dma_start = 0;
        burst_run(20, -1);
        chk("r_beats", grant_log[31:0], 32'h3);
        chk("r_rvalid", rv_log[31:0], 32'h6);
        chk("r_done_at", 32'(done_at), 2);
        chk("r_rq_left", 32'(rq.size()), 0);

        // Burst len 4 with CPU held: CPU,CPU,CPU,DMA repeating
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        start_write(32'h40, 4'd4, 32'hA0);
        #1;
        chk("s_idle_stall", 32'(cpu_stall), 0);
        chk("s_idle_cpu", cpu_rdata, 32'hDEADBEEF);
        step();
        dma_start = 0;
        burst_run(40, -1);
        chk("s_grants", grant_log[31:0], 32'h8888);
        chk("s_stalls", stall_log[31:0], 32'h8888);
        chk("s_done_at", 32'(done_at), 16);
        chk("s_wq_left", 32'(wq.size()), 0);
        cpu_req = 0;

        // Zero-length burst
        dma_we = 1; dma_len = 4'd0; dma_base = 32'h30; dma_start = 1;
        step();
        dma_start = 0;
        chk("z_done", 32'(dma_done), 1);
        chk("z_no_access", {30'd0, mem_we, mem_re}, 0);
        chk("z_busy", 32'(dma_busy), 0);
        step();
        chk("z_done_once", 32'(dma_done), 0);

        // dma_start during BURST ignored
        start_write(32'h60, 4'd3, 32'hB0);
        step();
        dma_start = 0;
        burst_run(30, 1);
        chk("i_done_at", 32'(done_at), 3);
        chk("i_grants", grant_log[31:0], 32'h7);
        chk("i_wq_left", 32'(wq.size()), 0);
        step();
        chk("i_idle_busy", 32'(dma_busy), 0);

        // Reset mid-burst
        start_write(32'h80, 4'd5, 32'hC0);
        while (wq.size() > 1) void'(wq.pop_back());
        step();
        dma_start = 0;
        step();
        rst = 1;
        step();
        chk("m_busy", 32'(dma_busy), 0);
        chk("m_done", 32'(dma_done), 0);
        rst = 0;
        step();
        chk("m_no_done", 32'(dma_done), 0);
        chk("m_idle_we", 32'(mem_we), 0);
        step();
        chk("m_wq_left", 32'(wq.size()), 0);
        chk("done_count", 32'(done_cnt), 5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a burst DMA/loader port.
- Owns the memory control inputs: write enable, read enable, address and write data.
- CPU has priority. A starvation counter guarantees that DMA bursts make forward progress.
- Sits between the MEM stage, the DMA engine and the data memory. It generates the CPU stall used by hazard logic.

Parameters:
- WORD_LEN, 32: data/address width; matches `WORD_LEN` in defines.v.
- BURST_W, 4: width of the DMA burst-length field. Maximum burst is 2^BURST_W-1 words.
- STARVE_MAX, 3: number of consecutive CPU grants allowed while a DMA beat is pending. The next cycle is then forced to DMA.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  MEM-stage access request (load or store)
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  WORD_LEN  byte-pair address
- cpu_wdata  in  WORD_LEN  store data
- cpu_rdata  out  WORD_LEN  load data, combinational, valid in the grant cycle
- cpu_stall  out  1  CPU request not served this cycle; the pipeline freezes
- dma_start  in  1  start burst; sampled only in IDLE
- dma_we  in  1  burst direction, 1 = write to memory
- dma_base  in  WORD_LEN  burst start address; bit 0 is forced to 0
- dma_len  in  BURST_W  number of words in the burst
- dma_wdata  in  WORD_LEN  current write word
- dma_wready  out  1  current write word consumed this cycle; present the next word
- dma_rdata  out  WORD_LEN  registered read word
- dma_rvalid  out  1  dma_rdata is valid (1 cycle after the read beat)
- dma_busy  out  1  burst in progress
- dma_done  out  1  one-cycle pulse after the last beat
- mem_we  out  1  memory writeEn
- mem_re  out  1  memory readEn
- mem_addr  out  WORD_LEN  memory address
- mem_wdata  out  WORD_LEN  memory dataIn
- mem_rdata  in  WORD_LEN  memory dataOut (combinational)

Behaviour:

State machine:
- States: IDLE, BURST, DONE.
- Registers: cur_addr, remaining (BURST_W bits), starve_cnt, latched dir.

IDLE:
- CPU always granted.
- dma_start with dma_len != 0: latch base & ~1, len and dir, then go to BURST.
- dma_start with dma_len == 0: go to DONE; no memory access occurs.

BURST, per-cycle grant decision (combinational):
- If cpu_req and starve_cnt < STARVE_MAX: grant CPU and increment starve_cnt.
- Otherwise: DMA beat; starve_cnt <= 0.

DMA beat:
- mem_addr = cur_addr.
- Write: mem_we = 1, mem_wdata = dma_wdata, dma_wready = 1.
- Read: mem_re = 1, dma_rdata <= mem_rdata, and dma_rvalid is 1 in the next cycle.
- cur_addr <= cur_addr + 2; wraps modulo 2^WORD_LEN with no bounds check.
- remaining <= remaining - 1. When remaining == 1, go to DONE.

CPU grant (any state):
- mem_addr = cpu_addr; mem_we = cpu_we; mem_re = ~cpu_we; mem_wdata = cpu_wdata.
- cpu_rdata = mem_rdata.

DONE:
- dma_done = 1 for exactly one cycle, then IDLE.
- CPU is served normally in DONE.

Output rules:
- cpu_stall = cpu_req & DMA granted this cycle. Never asserted in IDLE or DONE.
- No request granted: mem_we = mem_re = 0; mem_addr and mem_wdata = 0.
- dma_busy = (state == BURST).

Boundary conditions:
- dma_start while not IDLE: ignored.
- dma_start and cpu_req in the same IDLE cycle: CPU served; burst beats start the next cycle.
- Continuous cpu_req during a burst: DMA gets exactly 1 of every STARVE_MAX+1 cycles.

Reset:
- rst returns the block to IDLE and clears cur_addr, remaining and starve_cnt.
- All outputs are 0: dma_rvalid, dma_done, dma_wready, dma_busy, cpu_stall, mem_we, mem_re, dma_rdata, mem_addr, mem_wdata, cpu_rdata.
- Reset mid-burst aborts the burst with no dma_done pulse.

Decomposition:
- defines.v: add `DMEM_ARB_IDLE`, `DMEM_ARB_BURST` and `DMEM_ARB_DONE` state encodings (2 bits), and `DMEM_WORD_STRIDE` = 2. Reuse `WORD_LEN`.
- Optional sub-module dmem_starve_ctr: saturating counter with clear, compare output starve_hit.

Test Plan:
1. Reset, then CPU store 0xDEADBEEF @0x10 followed by load @0x10:
   - cpu_stall = 0 in both cycles.
   - cpu_rdata = 0xDEADBEEF in the load cycle.
2. DMA write burst, base 0x21, len 3, data 1,2,3, no CPU traffic:
   - mem_addr = 0x20, 0x22, 0x24 on consecutive cycles.
   - dma_wready high for 3 cycles; dma_done 1 cycle after the last beat.
   - CPU loads then return 1, 2, 3.
3. DMA read burst len 2 over the scenario-2 data:
   - dma_rvalid on the 2 cycles following each beat.
   - dma_rdata = 1 then 2.
4. Burst len 4 with cpu_req held high, STARVE_MAX = 3:
   - Grant pattern is CPU,CPU,CPU,DMA repeating.
   - cpu_stall high only in DMA cycles; done after 16 burst cycles.
5. Edge cases:
   - dma_len = 0 gives dma_done the next cycle with no mem_we/mem_re.
   - dma_start during BURST does not alter remaining.
   - rst asserted mid-burst: next cycle dma_busy = 0 and no dma_done pulse.
